// File: rtl/load_store_unit_pkg.sv
// Shared constants and encode helpers for the RV32I load/store unit:
// memory-op alucodes, byte-enable patterns and store lane encoding.
package load_store_unit_pkg;

  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  localparam logic [3:0] MEM_BE_BYTE0   = 4'b0001;
  localparam logic [3:0] MEM_BE_HALF_LO = 4'b0011;
  localparam logic [3:0] MEM_BE_HALF_HI = 4'b1100;
  localparam logic [3:0] MEM_BE_WORD    = 4'b1111;

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
           (op == ALU_LBU) || (op == ALU_LHU) || is_store_op(op);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    logic half_op;
    logic word_op;
    half_op = (op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH);
    word_op = (op == ALU_LW) || (op == ALU_SW);
    return (half_op && off[0]) || (word_op && (off != 2'b00));
  endfunction

  // Loads always fetch the whole word; the lane is picked on the way back.
  function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] off);
    case (op)
      ALU_SB:  return MEM_BE_BYTE0 << off;
      ALU_SH:  return off[1] ? MEM_BE_HALF_HI : MEM_BE_HALF_LO;
      default: return MEM_BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] sd);
    case (op)
      ALU_SB:  return {4{sd[7:0]}};
      ALU_SH:  return {2{sd[15:0]}};
      ALU_SW:  return sd;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load lane selection: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to the load alucode.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [5:0]  alucode,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = rdata >> {offset, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: data gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    data = '0;
    case (alucode)
      ALU_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      ALU_LBU: data = {24'h0, byte_sel};
      ALU_LH:  data = {{16{half_sel[15]}}, half_sel};
      ALU_LHU: data = {16'h0, half_sel};
      ALU_LW:  data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store, runs it over the req/ack
// bus and returns the extended load result; misaligned accesses bypass the bus.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        misalign_req;
  logic        ack_hit;
  logic [5:0]  op_q;
  logic [1:0]  offset_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;
  logic        misaligned_q;
  logic [31:0] align_data;

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    ack_hit      = 1'b0;
    misalign_req = is_misaligned(alucode, addr[1:0]);
    case (state_q)
      IDLE: begin
        if (req_valid && is_mem_op(alucode)) begin
          accept  = 1'b1;
          state_d = misalign_req ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          ack_hit = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: datapath registers are reset too, because they drive ports that must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      offset_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= alucode;
        offset_q    <= addr[1:0];
        mem_we_q    <= is_store_op(alucode);
        mem_addr_q  <= {addr[31:2], 2'b00};
        mem_be_q    <= store_be(alucode, addr[1:0]);
        mem_wdata_q <= store_wdata(alucode, store_data);
        if (misalign_req) begin
          misaligned_q <= 1'b1;
          load_data_q  <= '0;
        end
      end
      // Result registers change only when a response is produced, so they hold between responses.
      if (ack_hit) begin
        misaligned_q <= 1'b0;
        load_data_q  <= is_store_op(op_q) ? '0 : align_data;
      end
    end
  end

  lsu_load_align u_load_align (
    .rdata   (mem_rdata),
    .alucode (op_q),
    .offset  (offset_q),
    .data    (align_data)
  );

  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_req    = (state_q == ACCESS);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage for the RV32I core. Takes the effective address the ALU computes for load/store alucodes, plus store data, and runs one data-memory transaction over a req/ack bus. Produces byte-lane enables, replicated write data, and sign/zero-extended load results. It sits between execute and write-back, and stalls the core via `busy` while a transaction is outstanding.

## Interface
Parameters:
- None. Data and address width are fixed at 32.

Ports:
- `clk`  in  1  — the single clock; all state is updated on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — request strobe from execute.
- `alucode`  in  6  — operation; one of the `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW` macros.
- `addr`  in  32  — effective address (ALU result).
- `store_data`  in  32  — rs2 value.
- `busy`  out  1  — high whenever the FSM is not in IDLE.
- `resp_valid`  out  1  — one-cycle completion pulse.
- `load_data`  out  32  — extended load result; 0 for stores.
- `misaligned`  out  1  — qualifies `resp_valid`: the access was misaligned and was not performed.
- `mem_req`  out  1  — memory request; held until ack.
- `mem_we`  out  1  — 1 = store.
- `mem_addr`  out  32  — word address, `{addr[31:2],2'b00}`.
- `mem_be`  out  4  — byte enables.
- `mem_wdata`  out  32  — write data.
- `mem_rdata`  in  32  — read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  — one-cycle acknowledge.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE accepts a request when `req_valid` is high and `alucode` is a memory op. Non-memory alucodes are ignored and the FSM stays in IDLE.
- On accept, register the alucode, `addr[1:0]`, the memory address, the byte enables and the write data.
  - Next state is ACCESS.
  - If the access is misaligned, next state is RESP with `misaligned` set.
- Misaligned is defined as:
  - LH, LHU or SH with `addr[0]=1`.
  - LW or SW with `addr[1:0]!=0`.
- ACCESS: `mem_req=1`, and all `mem_*` outputs are held stable. When `mem_ack=1`, capture `mem_rdata` and go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then return to IDLE. A new request is not accepted in RESP.
- Store encoding (`k = addr[1:0]`):
  - SB: `be = 4'b0001<<k`, `wdata = {4{sd[7:0]}}`.
  - SH: `be = k[1] ? 4'b1100 : 4'b0011`, `wdata = {2{sd[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = sd`.
- Loads drive `mem_be=4'b1111` and `mem_we=0`.
- Load extract: take lane `k` (byte) or half `k[1]` from `rdata`.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Misaligned responses and store responses return `load_data=0`.

## Timing
- Reset values: state IDLE; `busy`, `resp_valid`, `misaligned`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `load_data` = 0.
- Reset asserted mid-ACCESS drops `mem_req` immediately (asynchronous). No response is produced.
- Latency, aligned access: accept in cycle 0, `mem_req` high in cycle 1. With `mem_ack` in cycle 1+n, `resp_valid` rises in cycle 2+n. The minimum is 2 cycles.
- Latency, misaligned access: `resp_valid` in cycle 1; `mem_req` is never asserted.
- `busy` is high from cycle 1 until the end of the RESP cycle.
- `load_data` and `misaligned` are registered. They are valid with `resp_valid` and hold until the next response.
- A `mem_ack` received outside ACCESS is ignored.
- `req_valid` is ignored while `busy`.

## Structure
- Memory-op alucode values stay in `define.vh`.
- Add `MEM_BE_*` constants to `define.vh`.
- FSM state encodings are local parameters.
- One sub-module, `lsu_load_align`: combinational lane select and extension, with inputs `rdata`, `alucode`, `offset[1:0]` and output `data[31:0]`.

## Test plan
- LB at `addr=0x1003`, ack in the first cycle with `rdata=0x80FF_1234` → `mem_addr=0x1000`, `mem_be=4'b1111`, `resp_valid` 2 cycles after accept, `load_data=0xFFFF_FF80`.
- LHU at `0x2002`, `rdata=0xBEEF_0000` → `load_data=0x0000_BEEF`. The same access as LH → `0xFFFF_BEEF`.
- SH at `0x3002`, `store_data=0x1234_ABCD`, ack after 3 wait cycles → `mem_we=1`, `mem_be=4'b1100`, `mem_wdata=0xABCD_ABCD`, with all `mem_*` outputs stable through the wait. `resp_valid` 5 cycles after accept.
- LW at `0x4001` → no `mem_req`; `resp_valid` with `misaligned=1` in cycle 1; `load_data=0`.
- Two back-to-back SB requests (the second presented while `busy`) → the second is ignored. After re-presenting it in IDLE: `mem_be=4'b0100` for addr `0x..2`, `wdata={4{byte}}`.
- `rst_n` low during ACCESS → `mem_req`, `busy` and `resp_valid` go 0 immediately. After release the FSM is in IDLE and accepts a new LW normally.
